// File: rtl/cm0_ctrl_pkg.sv
// Shared control-unit definitions: FSM state codes, reset-wait default and the
// strobe bundle. Also imported by the datapath testbench.
package cm0_ctrl_pkg;

    localparam int RESET_WAIT_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    typedef struct packed {
        logic cu_decode;
        logic cu_execute;
        logic ld_pc;
        logic ld_lr;
        logic ld_rd;
        logic ld_apsr;
        logic branch;
        logic wr_en;
    } strobes_t;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: INIT wait, fetch, decode, execute and
// writeback, with halt at instruction boundaries and a retired-instruction count.
module control_unit
    import cm0_ctrl_pkg::*;
#(
    parameter int RESET_WAIT = RESET_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        mem_ready,
    input  logic        update_flags,
    input  logic        write_rd,
    input  logic        ig_ex,
    input  logic        br_en,
    input  logic        br_link,
    input  logic        store_req,
    output logic        cu_decode,
    output logic        cu_execute,
    output logic        ld_pc,
    output logic        ld_lr,
    output logic        ld_rd,
    output logic        ld_apsr,
    output logic        branch,
    output logic        wr_en,
    output logic        ld_sp,
    output logic        ld_ipsr,
    output logic        ld_primask,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    localparam logic [3:0] INIT_LAST = 4'(RESET_WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  init_cnt_q, init_cnt_d;
    logic [31:0] retired_q, retired_d;
    strobes_t    strobes;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        retired_d  = retired_q;
        strobes    = '0;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d    = ST_FETCH;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end
            ST_FETCH: begin
                if (!en)            state_d = ST_HALT;
                else if (mem_ready) state_d = ST_DECODE;
            end
            ST_HALT: begin
                if (en) state_d = ST_FETCH;
            end
            ST_DECODE: begin
                strobes.cu_decode = 1'b1;
                // A failed condition skips execution and just advances the PC.
                if (ig_ex) begin
                    strobes.ld_pc = 1'b1;
                    state_d       = ST_FETCH;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                strobes.cu_execute = 1'b1;
                state_d            = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                strobes.wr_en = store_req;
                // Stores stall here until memory acknowledges; the ack cycle completes.
                if (!store_req || mem_ready) begin
                    strobes.ld_rd   = write_rd;
                    strobes.ld_apsr = update_flags;
                    strobes.ld_pc   = 1'b1;
                    strobes.branch  = br_en;
                    strobes.ld_lr   = br_en & br_link;
                    retired_d       = retired_q + 32'd1;
                    state_d         = ST_FETCH;
                end
            end
            default: begin
                state_d    = ST_INIT;
                init_cnt_d = '0;
            end
        endcase

        if (rst) strobes = '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            retired_q  <= retired_d;
        end
    end

    assign cu_decode  = strobes.cu_decode;
    assign cu_execute = strobes.cu_execute;
    assign ld_pc      = strobes.ld_pc;
    assign ld_lr      = strobes.ld_lr;
    assign ld_rd      = strobes.ld_rd;
    assign ld_apsr    = strobes.ld_apsr;
    assign branch     = strobes.branch;
    assign wr_en      = strobes.wr_en;
    assign ld_sp      = 1'b0;
    assign ld_ipsr    = 1'b0;
    assign ld_primask = 1'b0;
    assign state      = state_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each step queues the expected state, strobes
// and retire count, then pops and compares them mid-cycle.
module tb_control_unit;
    import cm0_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, mem_ready, update_flags, write_rd, ig_ex, br_en, br_link, store_req;
    logic        cu_decode, cu_execute, ld_pc, ld_lr, ld_rd, ld_apsr, branch, wr_en;
    logic        ld_sp, ld_ipsr, ld_primask;
    logic [2:0]  state;
    logic [31:0] retired;

    // Strobe vector bit masks: {dec, exe, pc, lr, rd, apsr, br, wr, sp, ipsr, primask}
    localparam logic [10:0] S_DEC  = 11'h400;
    localparam logic [10:0] S_EXE  = 11'h200;
    localparam logic [10:0] S_PC   = 11'h100;
    localparam logic [10:0] S_LR   = 11'h080;
    localparam logic [10:0] S_RD   = 11'h040;
    localparam logic [10:0] S_APSR = 11'h020;
    localparam logic [10:0] S_BR   = 11'h010;
    localparam logic [10:0] S_WR   = 11'h008;
    localparam logic [10:0] S_NONE = 11'h000;

    localparam logic [2:0] INIT = 3'd0, FETCH = 3'd1, DEC = 3'd2, EXE = 3'd3, WB = 3'd4, HALT = 3'd5;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [10:0] sb;
        logic [31:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [10:0] obs_sb;
    assign obs_sb = {cu_decode, cu_execute, ld_pc, ld_lr, ld_rd, ld_apsr, branch, wr_en,
                     ld_sp, ld_ipsr, ld_primask};

    control_unit dut (
        .clk(clk), .rst(rst), .en(en), .mem_ready(mem_ready),
        .update_flags(update_flags), .write_rd(write_rd), .ig_ex(ig_ex),
        .br_en(br_en), .br_link(br_link), .store_req(store_req),
        .cu_decode(cu_decode), .cu_execute(cu_execute), .ld_pc(ld_pc), .ld_lr(ld_lr),
        .ld_rd(ld_rd), .ld_apsr(ld_apsr), .branch(branch), .wr_en(wr_en),
        .ld_sp(ld_sp), .ld_ipsr(ld_ipsr), .ld_primask(ld_primask),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Queue an expectation for the current cycle, compare it at the falling edge,
    // then move to just after the next rising edge.
    task automatic cycle(input string tag, input logic [2:0] st, input logic [10:0] sb,
                         input logic [31:0] ret);
        exp_t e;
        e.tag = tag; e.st = st; e.sb = sb; e.ret = ret;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        assert (state === e.st) else begin
            errors++;
            $error("FAIL %s.state: got %0d expected %0d", e.tag, state, e.st);
        end
        checks++;
        assert (obs_sb === e.sb) else begin
            errors++;
            $error("FAIL %s.strobes: got %03h expected %03h", e.tag, obs_sb, e.sb);
        end
        checks++;
        assert (retired === e.ret) else begin
            errors++;
            $error("FAIL %s.retired: got %08h expected %08h", e.tag, retired, e.ret);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic wr, input logic fl, input logic br, input logic lk,
                           input logic ig, input logic sr);
        write_rd = wr; update_flags = fl; br_en = br; br_link = lk; ig_ex = ig; store_req = sr;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mem_ready = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        cycle("rst", INIT, S_NONE, 32'd0);

        // ALU op with Rd write and flag update
        rst = 1'b0; en = 1'b1; mem_ready = 1'b1;
        set_dec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("init0", INIT, S_NONE, 32'd0);
        cycle("init1", INIT, S_NONE, 32'd0);
        cycle("fetch1", FETCH, S_NONE, 32'd0);
        cycle("dec1", DEC, S_DEC, 32'd0);
        cycle("exe1", EXE, S_EXE, 32'd0);
        cycle("wb1", WB, S_RD | S_APSR | S_PC, 32'd0);

        // Branch with link
        set_dec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("fetch2", FETCH, S_NONE, 32'd1);
        cycle("dec2", DEC, S_DEC, 32'd1);
        cycle("exe2", EXE, S_EXE, 32'd1);
        cycle("wb2", WB, S_PC | S_BR | S_LR, 32'd1);

        // Fetch wait, then condition-failed op with br_en also set
        mem_ready = 1'b0;
        set_dec(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("fetch_wait", FETCH, S_NONE, 32'd2);
        mem_ready = 1'b1;
        cycle("fetch3", FETCH, S_NONE, 32'd2);
        cycle("dec3_igex", DEC, S_DEC | S_PC, 32'd2);

        // Store with three stalled writeback cycles
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("fetch4", FETCH, S_NONE, 32'd2);
        cycle("dec4", DEC, S_DEC, 32'd2);
        cycle("exe4", EXE, S_EXE, 32'd2);
        mem_ready = 1'b0;
        cycle("wb4_wait0", WB, S_WR, 32'd2);
        cycle("wb4_wait1", WB, S_WR, 32'd2);
        cycle("wb4_wait2", WB, S_WR, 32'd2);
        mem_ready = 1'b1;
        cycle("wb4_done", WB, S_WR | S_PC, 32'd2);

        // en dropped during EXECUTE: completes, then halts at the next fetch
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("fetch5", FETCH, S_NONE, 32'd3);
        cycle("dec5", DEC, S_DEC, 32'd3);
        en = 1'b0;
        cycle("exe5", EXE, S_EXE, 32'd3);
        cycle("wb5", WB, S_PC, 32'd3);
        cycle("fetch_halt", FETCH, S_NONE, 32'd4);
        cycle("halt0", HALT, S_NONE, 32'd4);
        en = 1'b1;
        cycle("halt1", HALT, S_NONE, 32'd4);

        // Retire counter wrap from all-ones
        mem_ready = 1'b0;
        force dut.retired_q = 32'hFFFF_FFFF;
        cycle("fetch_force", FETCH, S_NONE, 32'hFFFF_FFFF);
        release dut.retired_q;
        mem_ready = 1'b1;
        cycle("fetch7", FETCH, S_NONE, 32'hFFFF_FFFF);
        cycle("dec7", DEC, S_DEC, 32'hFFFF_FFFF);
        cycle("exe7", EXE, S_EXE, 32'hFFFF_FFFF);
        cycle("wb7", WB, S_PC, 32'hFFFF_FFFF);

        // One plain op so the count is nonzero, then reset mid-store
        cycle("fetch8", FETCH, S_NONE, 32'd0);
        cycle("dec8", DEC, S_DEC, 32'd0);
        cycle("exe8", EXE, S_EXE, 32'd0);
        cycle("wb8", WB, S_PC, 32'd0);
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("fetch9", FETCH, S_NONE, 32'd1);
        cycle("dec9", DEC, S_DEC, 32'd1);
        cycle("exe9", EXE, S_EXE, 32'd1);
        mem_ready = 1'b0;
        cycle("wb9_wait", WB, S_WR, 32'd1);
        rst = 1'b1;
        cycle("wb9_rst", WB, S_NONE, 32'd1);
        rst = 1'b0;
        cycle("post_rst", INIT, S_NONE, 32'd0);
        cycle("post_rst_init1", INIT, S_NONE, 32'd0);
        cycle("post_rst_fetch", FETCH, S_NONE, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter RESET_WAIT, default 2: cycles spent in INIT after reset release before the first fetch; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  run enable; low requests a halt at the next instruction boundary.
REQ-005 mem_ready  input  1  memory acknowledge for fetch and store.
REQ-006 update_flags, write_rd, ig_ex, br_en  input  1 each  decode results from the datapath (S bit, Rd write, condition failed, branch taken).
REQ-007 br_link  input  1  taken branch is branch-with-link.
REQ-008 store_req  input  1  current instruction writes memory.
REQ-009 cu_decode, cu_execute  output  1 each  datapath decode and execute strobes.
REQ-010 ld_pc, ld_lr, ld_rd, ld_apsr, branch, wr_en  output  1 each  datapath load and write enables.
REQ-011 ld_sp, ld_ipsr, ld_primask  output  1 each  reserved; driven 0 in this revision.
REQ-012 state  output  3  current FSM state code.
REQ-013 retired  output  32  count of completed instructions.

Function
REQ-014 FSM states and codes: INIT=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5; codes 6 and 7 are illegal and SHALL return to INIT on the next cycle.
REQ-015 INIT: an internal 4-bit counter SHALL count RESET_WAIT cycles, then the FSM moves to FETCH.
REQ-016 FETCH: if en=0, go to HALT; else wait for mem_ready=1, then go to DECODE; wait has no timeout.
REQ-017 HALT: all strobes 0; go to FETCH in the cycle after en is sampled 1.
REQ-018 DECODE: cu_decode=1 for exactly one cycle.
REQ-019 DECODE with ig_ex=1: ld_pc=1 and branch=0 in the same cycle; next state FETCH; EXECUTE is skipped and retired is not incremented.
REQ-020 DECODE with ig_ex=0: next state EXECUTE.
REQ-021 EXECUTE: cu_execute=1 for exactly one cycle; next state WRITEBACK.
REQ-022 WRITEBACK with store_req=1: wr_en=1 is held; all other strobes are 0 until the cycle mem_ready=1, which is the completion cycle.
REQ-023 WRITEBACK with store_req=0: the first cycle is the completion cycle.
REQ-024 WRITEBACK completion cycle drives:
- ld_rd = write_rd
- ld_apsr = update_flags
- ld_pc = 1
- branch = br_en
- ld_lr = br_en & br_link
REQ-025 WRITEBACK completion: retired increments by 1 and next state is FETCH.
REQ-026 Total latency without waits: fetch-to-next-fetch is 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK); ig_ex path is 2 cycles.
REQ-027 All strobes are decoded combinationally from the registered state and current inputs, and are 0 in every state/condition not listed above.
REQ-028 retired wraps from 32'hFFFFFFFF to 0 without a flag.
REQ-029 en=0 mid-instruction does not abort; the instruction completes and the halt is taken from the following FETCH.
REQ-030 br_en and ig_ex both 1 in DECODE: ig_ex wins and no branch is taken.

Reset
REQ-031 rst=1 at a clock edge SHALL force state=INIT, clear the INIT counter and set retired=0, overriding every other input, including mid-store (wr_en drops in the next cycle).
REQ-032 While in reset and INIT, every strobe output SHALL be 0.

Structure
REQ-033 State codes and the RESET_WAIT default SHALL live in shared package cm0_ctrl_pkg, which the datapath testbench also imports.
REQ-034 Single module with no sub-modules; the retire counter and INIT counter are inline registers.

Verification
REQ-035 rst for 1 cycle, en=1, mem_ready=1: state sequence 0,0,1,2,3,4,1; retired=1 after the first WRITEBACK.
REQ-036 Normal ALU op, write_rd=1, update_flags=1, br_en=0: the WRITEBACK cycle shows ld_rd=1, ld_apsr=1, ld_pc=1, branch=0, ld_lr=0.
REQ-037 br_en=1, br_link=1: the WRITEBACK cycle shows branch=1, ld_pc=1, ld_lr=1; ig_ex=1 in DECODE gives ld_pc=1, next state 1, retired unchanged.
REQ-038 store_req=1 with mem_ready held 0 for 3 cycles in WRITEBACK: wr_en=1 for 4 cycles, ld_pc=1 only in the 4th cycle.
REQ-039 en dropped during EXECUTE: WRITEBACK completes, then FETCH, then HALT (5) with strobes 0; en=1 returns to FETCH one cycle later.
REQ-040 Preload retired=32'hFFFFFFFF via force, complete one instruction: retired=0; rst asserted in WRITEBACK with wr_en=1: next cycle state=0, wr_en=0, retired=0.
